// File: rtl/step_dir_pkg.sv
// Shared types and default timing constants for the STEP/DIR position decoder.
package step_dir_pkg;

    typedef enum logic [1:0] {
        UNHOMED,
        HOMED,
        FAULT
    } dec_state_t;

    typedef enum logic [1:0] {
        FLT_NONE,
        FLT_TOO_FAST,
        FLT_DIR_SETUP,
        FLT_RANGE
    } fault_code_t;

    localparam int unsigned DEF_POS_W        = 16;
    localparam int unsigned DEF_POS_MAX      = 8000;
    localparam int unsigned DEF_MIN_PERIOD   = 400;
    localparam int unsigned DEF_DIR_SETUP    = 40;
    localparam int unsigned DEF_IDLE_TIMEOUT = 4_000_000;

endpackage

// File: rtl/step_dir_decoder_if.sv
// STEP/DIR decoder signal bundle: the printer side (master) drives the lines, the decoder reports.
interface step_dir_decoder_if #(
    parameter int unsigned POS_W = 16
);
    logic             step_in;
    logic             dir_in;
    logic             home_in;
    logic             clear_fault;
    logic [POS_W-1:0] pos;
    logic             pos_valid;
    logic             homed;
    logic             moving;
    logic             step_strobe;
    logic             fault;
    logic [1:0]       fault_code;

    modport master (
        output step_in, dir_in, home_in, clear_fault,
        input  pos, pos_valid, homed, moving, step_strobe, fault, fault_code
    );

    modport slave (
        input  step_in, dir_in, home_in, clear_fault,
        output pos, pos_valid, homed, moving, step_strobe, fault, fault_code
    );
endinterface

// File: rtl/sync_edge_det.sv
// 2-FF synchronizer with rise/fall detection. With STEP_DIR_GLITCH_FILTER_EN defined and
// FILT_EN set, the level only changes after 3 consecutive equal synchronized samples.
module sync_edge_det #(
    parameter bit FILT_EN = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
`ifdef STEP_DIR_GLITCH_FILTER_EN
    localparam bit FILTER_ON = FILT_EN;
`else
    localparam bit FILTER_ON = 1'b0 & FILT_EN;
`endif

    logic [1:0] r_sync;
    logic       r_level;
    logic       w_level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_async};
            r_level <= w_level;
        end
    end

    if (FILTER_ON) begin : g_filt
        logic [1:0] r_hist;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_hist <= 2'b00;
            end else begin
                r_hist <= {r_hist[0], r_sync[1]};
            end
        end

        // Level is taken from the live sample so the edge appears on the third equal sample.
        always_comb begin
            w_level = r_level;
            if (&{r_sync[1], r_hist}) begin
                w_level = 1'b1;
            end else if (~|{r_sync[1], r_hist}) begin
                w_level = 1'b0;
            end
        end
    end else begin : g_nofilt
        assign w_level = r_sync[1];
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_level;
    assign o_fall  = ~w_level & r_level;
endmodule

// File: rtl/step_dir_decoder.sv
// Rebuilds one axis' absolute position from STEP/DIR, referenced to its home switch, and
// flags timing/range violations. STEP_DIR_GLITCH_FILTER_EN enables the STEP glitch filter.
module step_dir_decoder
    import step_dir_pkg::*;
#(
    parameter int unsigned POS_W        = DEF_POS_W,
    parameter int unsigned POS_MAX      = DEF_POS_MAX,
    parameter int unsigned MIN_PERIOD   = DEF_MIN_PERIOD,
    parameter int unsigned DIR_SETUP    = DEF_DIR_SETUP,
    parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input logic                i_clk_40,
    input logic                i_rst,
    step_dir_decoder_if.slave  io_bus
);
    localparam int unsigned PER_W  = $clog2(MIN_PERIOD + 1);
    localparam int unsigned DS_W   = $clog2(DIR_SETUP + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    logic w_step_lvl, w_step_rise, w_step_fall;
    logic w_dir, w_dir_rise, w_dir_fall, w_dir_chg;
    logic w_home, w_home_rise, w_home_fall;
    logic w_unused;

    dec_state_t  r_state, w_state_d;
    fault_code_t r_code, w_code_d;
    logic [POS_W-1:0]  r_pos, w_pos_d;
    logic              r_strobe, w_strobe_d;
    logic              w_accept;
    logic [PER_W-1:0]  r_per_cnt;
    logic [DS_W-1:0]   r_ds_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;

    sync_edge_det #(.FILT_EN(1'b1)) u_step_sync (
        .i_clk   (i_clk_40),
        .i_rst   (i_rst),
        .i_async (io_bus.step_in),
        .o_level (w_step_lvl),
        .o_rise  (w_step_rise),
        .o_fall  (w_step_fall)
    );

    sync_edge_det #(.FILT_EN(1'b0)) u_dir_sync (
        .i_clk   (i_clk_40),
        .i_rst   (i_rst),
        .i_async (io_bus.dir_in),
        .o_level (w_dir),
        .o_rise  (w_dir_rise),
        .o_fall  (w_dir_fall)
    );

    sync_edge_det #(.FILT_EN(1'b0)) u_home_sync (
        .i_clk   (i_clk_40),
        .i_rst   (i_rst),
        .i_async (io_bus.home_in),
        .o_level (w_home),
        .o_rise  (w_home_rise),
        .o_fall  (w_home_fall)
    );

    assign w_dir_chg = w_dir_rise | w_dir_fall;
    assign w_unused  = ^{w_step_lvl, w_step_fall, w_home_rise, w_home_fall};

    always_ff @(posedge i_clk_40) begin
        if (i_rst) begin
            r_state  <= UNHOMED;
            r_code   <= FLT_NONE;
            r_pos    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_code   <= w_code_d;
            r_pos    <= w_pos_d;
            r_strobe <= w_strobe_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_code_d   = r_code;
        w_pos_d    = r_pos;
        w_strobe_d = 1'b0;
        w_accept   = 1'b0;
        unique case (r_state)
            UNHOMED: begin
                if (w_home) begin
                    w_state_d = HOMED;
                    w_pos_d   = '0;
                end
            end
            HOMED: begin
                // Home wins over a coincident step and never faults.
                if (w_home) begin
                    w_pos_d = '0;
                end else if (w_step_rise) begin
                    if (r_per_cnt < PER_W'(MIN_PERIOD)) begin
                        w_state_d = FAULT;
                        w_code_d  = FLT_TOO_FAST;
                    end else if (w_dir_chg || (r_ds_cnt < DS_W'(DIR_SETUP))) begin
                        w_state_d = FAULT;
                        w_code_d  = FLT_DIR_SETUP;
                    end else if (w_dir ? (r_pos == POS_W'(POS_MAX)) : (r_pos == '0)) begin
                        w_state_d = FAULT;
                        w_code_d  = FLT_RANGE;
                    end else begin
                        w_accept   = 1'b1;
                        w_strobe_d = 1'b1;
                        w_pos_d    = w_dir ? r_pos + 1'b1 : r_pos - 1'b1;
                    end
                end
            end
            FAULT: begin
                if (io_bus.clear_fault) begin
                    w_state_d = UNHOMED;
                    w_code_d  = FLT_NONE;
                    w_pos_d   = '0;
                end
            end
            default: begin
                w_state_d = UNHOMED;
            end
        endcase
    end

    always_ff @(posedge i_clk_40) begin
        if (i_rst) begin
            r_per_cnt  <= PER_W'(MIN_PERIOD);
            r_ds_cnt   <= DS_W'(DIR_SETUP);
            r_idle_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_per_cnt <= '0;
            end else if (r_per_cnt < PER_W'(MIN_PERIOD)) begin
                r_per_cnt <= r_per_cnt + 1'b1;
            end

            if (w_dir_chg) begin
                r_ds_cnt <= '0;
            end else if (r_ds_cnt < DS_W'(DIR_SETUP)) begin
                r_ds_cnt <= r_ds_cnt + 1'b1;
            end

            if (w_accept) begin
                r_idle_cnt <= IDLE_W'(IDLE_TIMEOUT);
            end else if (r_idle_cnt != '0) begin
                r_idle_cnt <= r_idle_cnt - 1'b1;
            end
        end
    end

    assign io_bus.pos         = r_pos;
    assign io_bus.pos_valid   = (r_state == HOMED);
    assign io_bus.homed       = (r_state == HOMED);
    assign io_bus.fault       = (r_state == FAULT);
    assign io_bus.fault_code  = r_code;
    assign io_bus.step_strobe = r_strobe;
    assign io_bus.moving      = (r_idle_cnt != '0);
endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder: homing, counting, each fault cause, clear, reset.
module tb_step_dir_decoder;
    localparam int unsigned POS_W  = 16;
    localparam int unsigned IDLE_T = 2000;
`ifdef STEP_DIR_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_strobes = 0;

    step_dir_decoder_if #(.POS_W(POS_W)) bus ();

    step_dir_decoder #(
        .POS_W        (POS_W),
        .POS_MAX      (8000),
        .MIN_PERIOD   (400),
        .DIR_SETUP    (40),
        .IDLE_TIMEOUT (IDLE_T)
    ) dut (
        .i_clk_40 (clk),
        .i_rst    (rst),
        .io_bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.step_strobe === 1'b1) n_strobes <= n_strobes + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; consumes exactly 'period' cycles from the STEP rise.
    task automatic step_pulse(input int period, input logic exp_strobe, input int exp_pos,
                              input string tag);
        bus.step_in = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        chk({tag, " early strobe"}, 32'(bus.step_strobe), 32'd0);
        @(negedge clk);
        chk({tag, " strobe"}, 32'(bus.step_strobe), 32'(exp_strobe));
        chk({tag, " pos"}, 32'(bus.pos), 32'(exp_pos));
        repeat (5) @(negedge clk);
        bus.step_in = 1'b0;
        repeat (period - LAT - 5) @(negedge clk);
    endtask

    task automatic home_pulse();
        bus.home_in = 1'b1;
        repeat (5) @(negedge clk);
        bus.home_in = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic clear_pulse();
        bus.clear_fault = 1'b1;
        @(negedge clk);
        bus.clear_fault = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.step_in     = 1'b0;
        bus.dir_in      = 1'b1;
        bus.home_in     = 1'b0;
        bus.clear_fault = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst pos", 32'(bus.pos), 32'd0);
        chk("rst pos_valid", 32'(bus.pos_valid), 32'd0);
        chk("rst homed", 32'(bus.homed), 32'd0);
        chk("rst moving", 32'(bus.moving), 32'd0);
        chk("rst strobe", 32'(bus.step_strobe), 32'd0);
        chk("rst fault", 32'(bus.fault), 32'd0);
        chk("rst code", 32'(bus.fault_code), 32'd0);
        rst = 1'b0;
        repeat (50) @(negedge clk);

        // Steps before homing are ignored
        step_pulse(500, 1'b0, 0, "unhomed");
        chk("unhomed homed", 32'(bus.homed), 32'd0);
        chk("unhomed strobes", 32'(n_strobes), 32'd0);

        home_pulse();
        chk("home homed", 32'(bus.homed), 32'd1);
        chk("home pos_valid", 32'(bus.pos_valid), 32'd1);
        chk("home pos", 32'(bus.pos), 32'd0);

        for (int i = 1; i <= 10; i++) begin
            step_pulse(500, 1'b1, i, "up");
            if (i == 1) chk("up moving", 32'(bus.moving), 32'd1);
        end
        chk("up final pos", 32'(bus.pos), 32'd10);
        chk("up strobes", 32'(n_strobes), 32'd10);

        // Count down to 0, then the next step is out of range
        bus.dir_in = 1'b0;
        repeat (100) @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            step_pulse(500, 1'b1, 10 - i, "down");
        end
        step_pulse(500, 1'b0, 0, "range");
        chk("range fault", 32'(bus.fault), 32'd1);
        chk("range code", 32'(bus.fault_code), 32'd3);
        step_pulse(500, 1'b0, 0, "in fault");
        chk("in fault code", 32'(bus.fault_code), 32'd3);
        chk("in fault homed", 32'(bus.homed), 32'd0);
        repeat (600) @(negedge clk);
        chk("idle moving", 32'(bus.moving), 32'd0);

        clear_pulse();
        chk("clear fault", 32'(bus.fault), 32'd0);
        chk("clear code", 32'(bus.fault_code), 32'd0);
        chk("clear pos", 32'(bus.pos), 32'd0);
        chk("clear pos_valid", 32'(bus.pos_valid), 32'd0);

        // Steps 300 cycles apart
        bus.dir_in = 1'b1;
        repeat (100) @(negedge clk);
        home_pulse();
        step_pulse(300, 1'b1, 1, "fast a");
        step_pulse(500, 1'b0, 1, "fast b");
        chk("fast code", 32'(bus.fault_code), 32'd1);
        chk("fast fault", 32'(bus.fault), 32'd1);

        // DIR toggled 10 cycles before STEP
        clear_pulse();
        home_pulse();
        step_pulse(500, 1'b1, 1, "setup a");
        bus.dir_in = 1'b0;
        repeat (10) @(negedge clk);
        step_pulse(500, 1'b0, 1, "setup b");
        chk("setup code", 32'(bus.fault_code), 32'd2);

        // Home and STEP rising together
        clear_pulse();
        bus.dir_in = 1'b1;
        repeat (100) @(negedge clk);
        home_pulse();
        for (int i = 1; i <= 5; i++) begin
            step_pulse(500, 1'b1, i, "pre home");
        end
        bus.home_in = 1'b1;
        step_pulse(500, 1'b0, 0, "home+step");
        bus.home_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("home+step fault", 32'(bus.fault), 32'd0);
        chk("home+step homed", 32'(bus.homed), 32'd1);
        chk("total strobes", 32'(n_strobes), 32'd27);

        // Reset one cycle after a STEP rise
        step_pulse(500, 1'b1, 1, "pre rst");
        bus.step_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        bus.step_in = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid rst pos", 32'(bus.pos), 32'd0);
        chk("mid rst homed", 32'(bus.homed), 32'd0);
        chk("mid rst moving", 32'(bus.moving), 32'd0);
        chk("mid rst strobes", 32'(n_strobes), 32'd28);

`ifdef STEP_DIR_GLITCH_FILTER_EN
        home_pulse();
        bus.step_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.step_in = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch pos", 32'(bus.pos), 32'd0);
        chk("glitch strobes", 32'(n_strobes), 32'd28);
        bus.step_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("filt early strobe", 32'(bus.step_strobe), 32'd0);
        bus.step_in = 1'b0;
        @(negedge clk);
        chk("filt strobe", 32'(bus.step_strobe), 32'd1);
        chk("filt pos", 32'(bus.pos), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/step_dir_decoder.md
Name: step_dir_decoder

Overview:
- Receiving end of the stepper STEP/DIR interface that the printer core drives on JB pins.
- Reconstructs one axis' absolute head position from STEP/DIR pulses, referenced to that axis' calibration (home) switch.
- Flags protocol violations: too-fast steps, DIR changed inside its setup window, travel out of range.
- One instance per axis; used for VGA head-position overlay and loopback checking of the printer core.

Parameters:
- POS_W, 16, width of the position counter.
- POS_MAX, 16'd8000, highest legal position in steps; legal range is 0..POS_MAX.
- MIN_PERIOD, 400, minimum clk_40 cycles between consecutive accepted STEP rising edges.
- DIR_SETUP, 40, minimum clk_40 cycles DIR must be stable before a STEP rising edge.
- IDLE_TIMEOUT, 4_000_000, clk_40 cycles without a step before moving drops.

Ports:
- clk_40  in  1  system clock, 40 MHz; sole clock.
- rst  in  1  synchronous, active-high reset.
- step_in  in  1  STEP line, asynchronous.
- dir_in  in  1  DIR line, asynchronous; 1 = increment, 0 = decrement.
- home_in  in  1  calibration switch, asynchronous, active-high.
- clear_fault  in  1  single-cycle pulse; leaves FAULT.
- pos  out  POS_W  current position in steps.
- pos_valid  out  1  high only in HOMED.
- homed  out  1  high in HOMED.
- moving  out  1  high for IDLE_TIMEOUT cycles after each accepted step.
- step_strobe  out  1  one-cycle pulse in the cycle pos changes.
- fault  out  1  high in FAULT.
- fault_code  out  2  0 none, 1 TOO_FAST, 2 DIR_SETUP, 3 RANGE; holds the first cause.

Behaviour:
- step_in, dir_in and home_in each pass a 2-FF synchronizer; STEP edge = sync & ~prev.
- Reset: pos=0, pos_valid=0, homed=0, moving=0, step_strobe=0, fault=0, fault_code=0, state=UNHOMED, period and setup counters saturated (first step is legal).
- States:
  - UNHOMED: steps ignored, pos held at 0. Synchronized home high -> HOMED, pos=0.
  - HOMED: home high forces pos=0 every cycle; on a simultaneous step edge, home wins and no fault is raised.
  - FAULT: steps and home ignored, pos frozen. clear_fault -> UNHOMED, fault_code=0, pos=0.
- Step edge in HOMED, with checks in priority order:
  - period counter < MIN_PERIOD -> FAULT, code 1;
  - else dir-stable counter < DIR_SETUP -> FAULT, code 2;
  - else dir=1 and pos==POS_MAX, or dir=0 and pos==0 -> FAULT, code 3;
  - else pos +/- 1, step_strobe=1, period counter cleared, moving set.
  - A faulting step never changes pos.
- Latency: pos and step_strobe update on the 3rd clk_40 rising edge after step_in goes high.
- Counters:
  - Dir-stable counter clears on any synchronized DIR change and saturates at DIR_SETUP.
  - Period counter saturates at MIN_PERIOD.
  - Idle counter reloads to IDLE_TIMEOUT on each accepted step; moving = (idle counter != 0).
- clear_fault outside FAULT has no effect.
- rst mid-operation returns everything to reset values on the next edge; no partial step is counted.

Optional Feature:
- Macro: STEP_DIR_GLITCH_FILTER_EN.
- Defined: synchronized STEP counts as high only after 3 consecutive high samples, and as low only after 3 consecutive low samples. Pulses of 2 cycles or fewer are ignored. Latency becomes 5 edges; the DIR_SETUP and MIN_PERIOD checks are applied at the filtered edge.
- Undefined: no filter, latency 3.

Decomposition:
- Package step_dir_pkg holds:
  - typedef enum dec_state_t {UNHOMED, HOMED, FAULT};
  - typedef enum fault_code_t {FLT_NONE, FLT_TOO_FAST, FLT_DIR_SETUP, FLT_RANGE};
  - default constants for MIN_PERIOD, DIR_SETUP and IDLE_TIMEOUT.
- Sub-module sync_edge_det: 2-FF synchronizer plus rise/fall detect; instantiated three times. The glitch filter sits inside it under the macro.

Test Plan:
- Reset, home_in pulse of 5 cycles, then 10 steps at 500-cycle period with dir=1 -> pos=10, homed=1, 10 step_strobe pulses, each 3 edges after step rise.
- From pos=10, 12 steps with dir=0 -> pos counts down to 0, then the 11th step raises fault, code 3, pos stays 0. clear_fault -> UNHOMED, pos=0, pos_valid=0.
- Homed, two steps 300 cycles apart -> second step raises fault code 1, pos incremented once.
- Homed, DIR toggled 10 cycles before a step -> fault code 2, pos unchanged.
- Homed at pos=5, home_in and step_in rising in the same cycle -> pos=0, no fault. Also: steps sent in UNHOMED leave pos=0 and step_strobe low.
- Macro defined: 2-cycle STEP glitch -> no count; 4-cycle STEP pulse -> count, with step_strobe 5 edges after the rise. Also: rst asserted 1 cycle after a step rise -> pos=0, no strobe.
